sr_regdump: RTL

SR_REGDUMP -- requirements
Module: sr_regdump

---
 rtl/sr_regdump.sv | 102 ++++++++++
 1 files changed

// File: rtl/sr_regdump.sv
// Walks the CPU debug read port from FIRST_REG to LAST_REG and streams each
// captured register out over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for start; regAddr holds its last value
// SETTLE | regAddr driven, waiting one cycle for regData to become valid
// SEND   | captured word presented on out_addr/out_data until accepted
// FINISH | last word accepted; done pulses for this single cycle
module sr_regdump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $error("sr_regdump: register range must satisfy 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  typedef enum logic [1:0] {IDLE, SETTLE, SEND, FINISH} state_t;

  state_t     state, state_nxt;
  logic [4:0] addr_nxt;
  logic       valid_nxt;
  logic       capture;

  always_comb begin
    state_nxt = state;
    addr_nxt  = regAddr;
    valid_nxt = out_valid;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          addr_nxt  = FIRST_ADDR;
        end
      end
      SETTLE: begin
        state_nxt = SEND;
        capture   = 1'b1;
        valid_nxt = 1'b1;
      end
      SEND: begin
        if (out_ready) begin
          valid_nxt = 1'b0;
          if (regAddr == LAST_ADDR) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = SETTLE;
            addr_nxt  = regAddr + 5'd1;
          end
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything above, including a pending handshake.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      addr_nxt  = regAddr;
      valid_nxt = 1'b0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      regAddr   <= 5'd0;
      out_valid <= 1'b0;
      out_addr  <= 5'd0;
      out_data  <= 32'd0;
    end else begin
      state     <= state_nxt;
      regAddr   <= addr_nxt;
      out_valid <= valid_nxt;
      if (capture) begin
        out_addr <= regAddr;
        out_data <= regData;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

endmodule
